// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its line synchroniser.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    WAIT_IDLE,
    DONE
  } ps2_state_t;

  localparam logic [3:0] BITCNT_PARITY = 4'd9;
  localparam logic [3:0] BITCNT_STOP   = 4'd10;
  localparam logic [3:0] BITCNT_ACK    = 4'd11;

  localparam int MAX_RETRIES = 2;

  // PS/2 frames carry odd parity: data bits plus parity bit hold an odd count of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser plus falling-edge detector for one PS/2 line.
// Flops reset to 1 (idle bus level) so leaving reset never fakes an edge.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // Synchronise the raw pin and keep one extra stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      sync_p0 <= pin;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign fall  = prev_p2 & ~sync_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (clk8 domain).
// Only ever pulls lines low; the top level turns the DriveLow outputs into tristate pins.
// Optional macro PS2_HOST_TX_RETRY_EN: failed attempts restart automatically, up to
// MAX_RETRIES extra attempts with the same latched byte.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 8000000,
  parameter int INHIBIT_CYCLES = CLK_HZ / 10000,
  parameter int TIMEOUT_CYCLES = CLK_HZ / 1000 * 15
) (
  input  logic       clk8,
  input  logic       _reset,
  input  logic [7:0] txData,
  input  logic       txStart,
  output logic       txBusy,
  output logic       txDone,
  output logic       txError,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkDriveLow,
  output logic       ps2DataDriveLow
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0] bit_cnt, bit_nxt;
  logic [7:0] tx_byte, byte_nxt;
  logic parity, parity_nxt;
  logic data_low, data_low_nxt;
  logic clk_low;
  logic ack_err, ack_err_nxt;
  logic clk_level, clk_fall, data_level;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRIES);
  logic [1:0] retry_cnt, retry_nxt;
`endif

  ps2_sync_edge u_clk_sync (
    .clk   (clk8),
    .rst_n (_reset),
    .pin   (ps2ClkIn),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk   (clk8),
    .rst_n (_reset),
    .pin   (ps2DataIn),
    .level (data_level),
    .fall  ()
  );

  // Next-state logic; the data drive is computed one cycle ahead so both pin drivers are flops.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_nxt      = bit_cnt;
    byte_nxt     = tx_byte;
    parity_nxt   = parity;
    data_low_nxt = data_low;
    ack_err_nxt  = ack_err;
`ifdef PS2_HOST_TX_RETRY_EN
    retry_nxt    = retry_cnt;
`endif
    case (state)
      IDLE: begin
        if (txStart) begin
          byte_nxt     = txData;
          parity_nxt   = odd_parity(txData);
          cnt_nxt      = '0;
          bit_nxt      = '0;
          ack_err_nxt  = 1'b0;
          data_low_nxt = 1'b0;
          state_nxt    = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
          retry_nxt    = '0;
`endif
        end
      end
      INHIBIT: begin
        if (cnt == INH_LAST) begin
          state_nxt = REQ;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      REQ: begin
        bit_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (clk_fall) begin
          bit_nxt = bit_cnt + 4'd1;
          if (bit_nxt <= 4'd8) begin
            data_low_nxt = ~tx_byte[bit_cnt[2:0]];
          end else if (bit_nxt == BITCNT_PARITY) begin
            data_low_nxt = ~parity;
          end else if (bit_nxt == BITCNT_STOP) begin
            data_low_nxt = 1'b0;
          end else begin
            ack_err_nxt = data_level;
            state_nxt   = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_level && data_level) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Whole-transaction watchdog; overrides any edge seen in the same cycle.
    if (state == REQ || state == SHIFT || state == WAIT_IDLE) begin
      if (cnt == TMO_LAST) begin
        state_nxt    = DONE;
        data_low_nxt = 1'b0;
        ack_err_nxt  = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end

`ifdef PS2_HOST_TX_RETRY_EN
    // A failing attempt re-enters INHIBIT instead of reporting, while retries remain.
    if (state != DONE && state_nxt == DONE && ack_err_nxt && retry_cnt != RETRY_LIMIT) begin
      state_nxt    = INHIBIT;
      cnt_nxt      = '0;
      data_low_nxt = 1'b0;
      ack_err_nxt  = 1'b0;
      retry_nxt    = retry_cnt + 2'd1;
    end
`endif

    // Start bit: data goes low in the final inhibit cycle.
    if (state_nxt == INHIBIT && cnt_nxt == INH_LAST) data_low_nxt = 1'b1;
  end

  // State and datapath registers; reset releases both lines asynchronously.
  always_ff @(posedge clk8 or negedge _reset) begin
    if (!_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_byte  <= '0;
      parity   <= 1'b0;
      data_low <= 1'b0;
      clk_low  <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_cnt  <= bit_nxt;
      tx_byte  <= byte_nxt;
      parity   <= parity_nxt;
      data_low <= data_low_nxt;
      clk_low  <= (state_nxt == INHIBIT);
      ack_err  <= ack_err_nxt;
    end
  end

`ifdef PS2_HOST_TX_RETRY_EN
  // Attempt counter for automatic retries.
  always_ff @(posedge clk8 or negedge _reset) begin
    if (!_reset) retry_cnt <= '0;
    else         retry_cnt <= retry_nxt;
  end
`endif

  assign txBusy          = (state != IDLE);
  assign txDone          = (state == DONE);
  assign txError         = (state == DONE) & ack_err;
  assign ps2ClkDriveLow  = clk_low;
  assign ps2DataDriveLow = data_low;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 800;
  localparam int TMO  = 6000;
  localparam int HALF = 160;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk8 = 1'b0;
  logic       _reset;
  logic [7:0] txData;
  logic       txStart;
  logic       txBusy, txDone, txError, ps2ClkDriveLow, ps2DataDriveLow;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       ps2ClkIn, ps2DataIn;

  int checks = 0, errors = 0;
  int cyc = 0, run = 0, last_run = 0, inhibit_phases = 0, done_count = 0;
  bit   exp_err_q[$];
  bit   exp_bits_q[$];
  logic wire_q[$];

  assign ps2ClkIn  = dev_clk & ~ps2ClkDriveLow;
  assign ps2DataIn = dev_data & ~ps2DataDriveLow;

  always #62.5 clk8 = ~clk8;

  ps2_host_tx #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk8            (clk8),
    ._reset          (_reset),
    .txData          (txData),
    .txStart         (txStart),
    .txBusy          (txBusy),
    .txDone          (txDone),
    .txError         (txError),
    .ps2ClkIn        (ps2ClkIn),
    .ps2DataIn       (ps2DataIn),
    .ps2ClkDriveLow  (ps2ClkDriveLow),
    .ps2DataDriveLow (ps2DataDriveLow)
  );

  always @(posedge clk8) cyc <= cyc + 1;

  always @(negedge clk8) begin
    if (ps2ClkDriveLow) run <= run + 1;
    else if (run != 0) begin
      last_run       <= run;
      inhibit_phases <= inhibit_phases + 1;
      run            <= 0;
    end
    if (txDone) done_count <= done_count + 1;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic start_tx(input logic [7:0] d, input bit exp_err);
    int ones;
    ones = 0;
    @(negedge clk8);
    txData  = d;
    txStart = 1'b1;
    exp_bits_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_bits_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    exp_bits_q.push_back((ones % 2) == 0);
    exp_bits_q.push_back(1'b1);
    exp_err_q.push_back(exp_err);
    @(negedge clk8);
    txStart = 1'b0;
  endtask

  task automatic wait_req(output bit seen, output int req_at);
    bit inh;
    inh = 0; seen = 0; req_at = 0;
    for (int i = 0; i < TMO + 4000; i++) begin
      @(negedge clk8);
      if (ps2ClkDriveLow) inh = 1;
      else if (inh) begin
        seen = 1; req_at = cyc;
        break;
      end
    end
  endtask

  task automatic dev_run(input bit ack, input int pulses, output bit seen);
    int req_at;
    wait_req(seen, req_at);
    if (!seen) return;
    repeat (20) @(negedge clk8);
    wire_q.push_back(ps2DataIn);
    for (int n = 1; n <= pulses; n++) begin
      if (n == 11) dev_data = ack ? 1'b0 : 1'b1;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk8);
      if (n <= 10) wire_q.push_back(ps2DataIn);
      if (n == pulses && pulses < 11) return;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk8);
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input int limit, output bit got, output bit err, output int at,
                           output bit lines_rel);
    got = 0; err = 0; at = 0; lines_rel = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk8);
      if (txDone) begin
        got = 1; err = txError; at = cyc;
        lines_rel = !ps2ClkDriveLow && !ps2DataDriveLow;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [4:0] outs;
    _reset = 1'b0; txStart = 1'b0; txData = 8'h00;
    repeat (3) @(negedge clk8);
    outs = {txBusy, txDone, txError, ps2ClkDriveLow, ps2DataDriveLow};
    checks++;
    if (outs !== 5'b0) begin errors++; $display("FAIL reset_outputs got %b want 00000", outs); end
    _reset = 1'b1;
    repeat (3) @(negedge clk8);
    outs = {txBusy, txDone, txError, ps2ClkDriveLow, ps2DataDriveLow};
    checks++;
    if (outs !== 5'b0) begin errors++; $display("FAIL idle_outputs got %b want 00000", outs); end
  endtask

  task automatic test_transfer(input logic [7:0] d, input bit ack, input string name);
    bit seen, got, err, rel, exp_err, e;
    logic g;
    int at, d0, p0, attempts;
    d0 = done_count; p0 = inhibit_phases;
    attempts = ack ? 1 : ATTEMPTS;
    start_tx(d, !ack);
    checks++;
    if (txBusy !== 1'b1) begin errors++; $display("FAIL %s busy_after_accept got %b want 1", name, txBusy); end
    fork
      for (int a = 0; a < attempts; a++) dev_run(ack, 11, seen);
      wait_done(attempts * (TMO + 2000), got, err, at, rel);
    join
    checks++;
    if (!seen) begin errors++; $display("FAIL %s req_seen got 0 want 1", name); end
    checks++;
    if (!got) begin errors++; $display("FAIL %s done_seen got 0 want 1", name); end
    exp_err = exp_err_q.pop_front();
    checks++;
    if (err !== exp_err) begin errors++; $display("FAIL %s txError got %b want %b", name, err, exp_err); end
    checks++;
    if (!rel) begin errors++; $display("FAIL %s lines_released got 0 want 1", name); end
    for (int i = 0; i < 11; i++) begin
      e = exp_bits_q.pop_front();
      g = (wire_q.size() != 0) ? wire_q.pop_front() : 1'bx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s wire_bit%0d got %b want %b", name, i, g, e); end
    end
    wire_q.delete(); exp_bits_q.delete();
    checks++;
    if (last_run != INH) begin errors++; $display("FAIL %s inhibit_len got %0d want %0d", name, last_run, INH); end
    @(negedge clk8);
    checks++;
    if (txBusy !== 1'b0) begin errors++; $display("FAIL %s busy_after_done got %b want 0", name, txBusy); end
    repeat (5) @(negedge clk8);
    checks++;
    if (done_count - d0 != 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", name, done_count - d0); end
    checks++;
    if (inhibit_phases - p0 != attempts) begin
      errors++; $display("FAIL %s inhibit_phases got %0d want %0d", name, inhibit_phases - p0, attempts);
    end
  endtask

  task automatic test_timeout();
    bit seen, got, err, rel, exp_err;
    int req_at, at, d0;
    d0 = done_count;
    start_tx(8'h3C, 1'b1);
    fork
      for (int a = 0; a < ATTEMPTS; a++) wait_req(seen, req_at);
      wait_done(ATTEMPTS * (TMO + 2000), got, err, at, rel);
    join
    exp_bits_q.delete();
    exp_err = exp_err_q.pop_front();
    checks++;
    if (!(seen && got)) begin errors++; $display("FAIL timeout_events got req=%b done=%b want 1 1", seen, got); end
    checks++;
    if (at - req_at != TMO) begin errors++; $display("FAIL timeout_latency got %0d want %0d", at - req_at, TMO); end
    checks++;
    if (err !== exp_err) begin errors++; $display("FAIL timeout_txError got %b want %b", err, exp_err); end
    checks++;
    if (!rel) begin errors++; $display("FAIL timeout_lines_released got 0 want 1"); end
    repeat (5) @(negedge clk8);
    checks++;
    if (done_count - d0 != 1) begin errors++; $display("FAIL timeout_done_pulses got %0d want 1", done_count - d0); end
  endtask

  task automatic test_busy_ignore();
    bit seen, got, err, rel, exp_err, e;
    logic g;
    int at, d0, p0;
    d0 = done_count; p0 = inhibit_phases;
    start_tx(8'hF4, 1'b0);
    fork
      dev_run(1'b1, 11, seen);
      wait_done(TMO + 2000, got, err, at, rel);
      begin
        repeat (100) @(negedge clk8);
        txData = 8'h00; txStart = 1'b1;
        @(negedge clk8); txStart = 1'b0;
        repeat (2000) @(negedge clk8);
        txData = 8'h00; txStart = 1'b1;
        @(negedge clk8); txStart = 1'b0;
      end
    join
    exp_err = exp_err_q.pop_front();
    checks++;
    if (!got || err !== exp_err) begin errors++; $display("FAIL busy_ignore_done got done=%b err=%b want 1 %b", got, err, exp_err); end
    for (int i = 0; i < 11; i++) begin
      e = exp_bits_q.pop_front();
      g = (wire_q.size() != 0) ? wire_q.pop_front() : 1'bx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL busy_ignore_wire_bit%0d got %b want %b", i, g, e); end
    end
    wire_q.delete(); exp_bits_q.delete();
    repeat (2000) @(negedge clk8);
    checks++;
    if (done_count - d0 != 1) begin errors++; $display("FAIL busy_ignore_done_pulses got %0d want 1", done_count - d0); end
    checks++;
    if (inhibit_phases - p0 != 1) begin errors++; $display("FAIL busy_ignore_inhibits got %0d want 1", inhibit_phases - p0); end
    checks++;
    if (txBusy !== 1'b0) begin errors++; $display("FAIL busy_ignore_idle got %b want 0", txBusy); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic [2:0] outs;
    start_tx(8'hA5, 1'b0);
    dev_run(1'b1, 5, seen);
    checks++;
    if (!seen || ps2DataDriveLow !== 1'b1) begin
      errors++; $display("FAIL reset_mid_bit4_driven got %b want 1", ps2DataDriveLow);
    end
    #10 _reset = 1'b0;
    #1;
    outs = {ps2ClkDriveLow, ps2DataDriveLow, txBusy};
    checks++;
    if (outs !== 3'b000) begin errors++; $display("FAIL reset_mid_release got %b want 000", outs); end
    dev_clk = 1'b1; dev_data = 1'b1;
    exp_bits_q.delete(); exp_err_q.delete(); wire_q.delete();
    repeat (3) @(negedge clk8);
    _reset = 1'b1;
    repeat (3) @(negedge clk8);
  endtask

`ifdef PS2_HOST_TX_RETRY_EN
  task automatic test_retry();
    bit s1, s2, s3, got, err, rel, exp_err;
    int at, d0, p0;
    d0 = done_count; p0 = inhibit_phases;
    start_tx(8'hF4, 1'b0);
    fork
      begin
        dev_run(1'b0, 11, s1);
        dev_run(1'b0, 11, s2);
        dev_run(1'b1, 11, s3);
      end
      wait_done(4 * (TMO + 2000), got, err, at, rel);
    join
    exp_err = exp_err_q.pop_front();
    exp_bits_q.delete(); wire_q.delete();
    checks++;
    if (!(s1 && s2 && s3 && got)) begin errors++; $display("FAIL retry_events got %b%b%b%b want 1111", s1, s2, s3, got); end
    checks++;
    if (err !== exp_err) begin errors++; $display("FAIL retry_txError got %b want %b", err, exp_err); end
    repeat (5) @(negedge clk8);
    checks++;
    if (inhibit_phases - p0 != 3) begin errors++; $display("FAIL retry_inhibits got %0d want 3", inhibit_phases - p0); end
    checks++;
    if (done_count - d0 != 1) begin errors++; $display("FAIL retry_done_pulses got %0d want 1", done_count - d0); end
  endtask
`endif

  initial begin
    _reset = 1'b0; txStart = 1'b0; txData = 8'h00;
    test_reset();
    test_transfer(8'hF4, 1'b1, "send_f4");
    test_transfer(8'hFF, 1'b0, "nack_ff");
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    test_transfer(8'h5A, 1'b1, "after_reset");
`ifdef PS2_HOST_TX_RETRY_EN
    test_retry();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It sends one command byte, e.g. 0xF4 "enable data reporting", to the mouse on the shared mouseClk/mouseData open-drain pair.
- It is the transmit direction that complements the existing PS/2 mouse receive path in the data controller.
- It sits in the clk8 domain beside the mouse receiver. The top level converts its drive-low enables to tristate pins.

Parameters:
- CLK_HZ, 8000000: clk8 frequency, used only to derive the defaults below.
- INHIBIT_CYCLES, 800: clock-inhibit hold time (100 us at 8 MHz).
- TIMEOUT_CYCLES, 120000: whole-transaction limit after inhibit ends (15 ms).

Ports:
- clk8  in  1  system clock
- _reset  in  1  asynchronous active-low reset
- txData  in  8  command byte, sampled on an accepted txStart
- txStart  in  1  one-cycle request; accepted only in IDLE
- txBusy  out  1  high from the cycle after acceptance until txDone
- txDone  out  1  one-cycle pulse at the end of every transaction
- txError  out  1  valid with txDone: 1 = no ack or timeout
- ps2ClkIn  in  1  raw mouseClk pin level
- ps2DataIn  in  1  raw mouseData pin level
- ps2ClkDriveLow  out  1  1 = pull mouseClk low, 0 = release
- ps2DataDriveLow  out  1  1 = pull mouseData low, 0 = release

Behaviour:
- Interface: one clock (clk8); reset is asynchronous and active-low (_reset).
- Reset values: all outputs 0 (both lines released), state IDLE, counters 0. Asserting _reset mid-transaction releases both lines immediately and asynchronously.
- Inputs are 2-FF synchronised. A falling edge (fallClk) is registered-previous = 1 and current = 0. Detection latency is 3 cycles, well inside the ≥30 us PS/2 half-period.
- Accept: txStart in IDLE latches txData and computes parity = ~^txData (odd parity). txStart outside IDLE is ignored and never queued.
- IDLE: lines released, txBusy = 0.
- INHIBIT: ps2ClkDriveLow = 1 for exactly INHIBIT_CYCLES cycles.
  - In the last of those cycles ps2DataDriveLow becomes 1 (start bit).
  - Next state is REQ.
- REQ: release clock, keep data low, clear bitCnt, start the timeout counter. Go to SHIFT.
- SHIFT: on each fallClk, bitCnt increments (n = new count).
  - n = 1..8: ps2DataDriveLow = ~txData[n-1] (LSB first).
  - n = 9: ps2DataDriveLow = ~parity.
  - n = 10: release data (stop bit).
  - n = 11: sample synchronised data. 0 = ack; 1 = ackError set. Go to WAIT_IDLE.
- WAIT_IDLE: wait until synchronised clk = 1 and data = 1. Then go to DONE.
- DONE: one cycle; txDone = 1, txError = ackError; next state IDLE.
- Timeout: the counter runs in REQ, SHIFT and WAIT_IDLE. When it reaches TIMEOUT_CYCLES-1:
  - release both lines;
  - set txError;
  - go directly to DONE.
  - Timeout takes priority over a simultaneous fallClk.
- Lines are only ever driven low, never high. The top converts DriveLow = 1 to pin 0 and otherwise to Z.
- Receiver coexistence: the mouse receiver sees its own traffic during transmission. The top gates mouse receive with txBusy; this block has no receive function.

Optional Feature:
- Macro PS2_HOST_TX_RETRY_EN.
- Defined: a transaction ending in error (nack or timeout) restarts at INHIBIT automatically, up to 2 retries, with the same latched byte.
  - txBusy stays high throughout.
  - txDone pulses once, after success or after the third failure. txError reflects the final attempt.
- Undefined: no retry; a single attempt per txStart.

Decomposition:
- Package ps2_pkg:
  - state enum {IDLE, INHIBIT, REQ, SHIFT, WAIT_IDLE, DONE};
  - constants BITCNT_PARITY = 9, BITCNT_STOP = 10, BITCNT_ACK = 11;
  - MAX_RETRIES = 2.
- Sub-module ps2_sync_edge: 2-FF synchroniser plus falling-edge detector for one line.
  - Instantiated for clock and data.
  - Reusable by the mouse receiver.

Test Plan:
- Send 0xF4; device model clocks 11 pulses with a 40 us period and acks low.
  - Expect ps2ClkDriveLow high for exactly 800 cycles.
  - Expect bits 0,0,1,0,1,1,1,1 on the wire, then parity 0, stop released.
  - Expect txDone with txError = 0 and txBusy low the cycle after.
- Send 0xFF (parity 1); device holds data high at the ack edge → txError = 1 with txDone; both lines released.
- Device never clocks after REQ → txDone/txError = 1 exactly 120000 cycles after REQ; lines released.
- Pulse txStart with 0x00 while busy sending 0xF4 → ignored; wire carries 0xF4 only; exactly one txDone.
- Assert _reset during SHIFT (bit 5) → both DriveLow outputs 0 immediately; txBusy 0; a fresh txStart after reset completes normally.
- With PS2_HOST_TX_RETRY_EN: model nacks twice then acks → three INHIBIT phases observed; a single txDone with txError = 0.
